// File: rtl/mem_responder.sv
// mem_responder: LC-3 memory target with wait states and one-cycle ready pulse.
// Define LC3_MMIO_EN to map IO_ADDR onto SW (read) and HEX_Out (write).
module mem_responder #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ready,
    output logic        busy,
    input  logic [15:0] SW,
    output logic [15:0] HEX_Out
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] CNT_INIT = WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] ram [2**ADDR_W];
    logic        accept;
    logic        to_resp;
    logic        rd_we;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic        io_q;
    logic        commit;
    assign accept  = state == IDLE && mem_req;
    assign to_resp = (accept && WAIT_STATES == 0) || (state == WAIT && cnt == 4'd0);
    // With zero wait states the read happens on the accept edge, before the latches are valid
    assign rd_addr = state == IDLE ? mem_addr : addr_q;
    assign rd_we   = state == IDLE ? mem_we : we_q;
    assign commit  = state == RESP && we_q && !Reset;
`ifdef LC3_MMIO_EN
    assign rd_data = rd_addr == IO_ADDR ? SW : ram[rd_addr[ADDR_W-1:0]];
    assign io_q    = addr_q == IO_ADDR;
    always_ff @(posedge Clk) begin
        if (Reset)
            HEX_Out <= '0;
        else if (commit && io_q)
            HEX_Out <= wdata_q;
    end
`else
    logic unused_bits;
    assign rd_data     = ram[rd_addr[ADDR_W-1:0]];
    assign io_q        = 1'b0;
    assign HEX_Out     = '0;
    assign unused_bits = ^{SW, rd_addr, addr_q, IO_ADDR};
`endif
    // Writes land as RESP ends, so a reset during RESP still discards them
    always_ff @(posedge Clk) begin
        if (commit && !io_q)
            ram[addr_q[ADDR_W-1:0]] <= wdata_q;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= to_resp;
            if (to_resp && !rd_we)
                mem_rdata <= rd_data;
            case (state)
                IDLE: if (mem_req) begin
                    we_q    <= mem_we;
                    addr_q  <= mem_addr;
                    wdata_q <= mem_wdata;
                    busy    <= 1'b1;
                    cnt     <= CNT_INIT;
                    state   <= WAIT_STATES == 0 ? RESP : WAIT;
                end
                WAIT: begin
                    state <= cnt == 4'd0 ? RESP : WAIT;
                    if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
